// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned E1_CNT_W  = 3;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  // Bytes following an E1 prefix that belong to the Pause sequence
  localparam logic [E1_CNT_W-1:0] E1_SKIP = E1_CNT_W'(7);

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// PS/2 line inputs and decoded scan-code outputs of the receiver.
interface ps2_rx_ctrl_if;

  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       ps2_data_clk;
  logic [7:0] ps2_data;
  logic       ps2_ext;
  logic       frame_err;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  ps2_data_clk, ps2_data, ps2_ext, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output ps2_data_clk, ps2_data, ps2_ext, frame_err
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, deglitches PS2_CLK and emits a one-cycle
// event on each filtered falling edge together with the data level sampled then.
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_evt,
  output logic o_evt_dat
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_accept;

  // A level change is taken only after FILT_LEN consecutive differing samples
  assign w_diff   = (r_clk_sync[1] != r_filt);
  assign w_accept = w_diff && (r_cnt == CNT_W'(FILT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_cnt      <= '0;
      o_evt      <= 1'b0;
      o_evt_dat  <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
      if (!w_diff || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_filt <= r_clk_sync[1];
      end
      o_evt     <= w_accept && r_filt;
      o_evt_dat <= r_dat_sync[1];
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: frames bytes off the line, checks parity/stop/timeout
// and folds E0/E1/F0 prefixes into strobed scan codes for the keyboard matrix.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  ps2_rx_ctrl_if.slave  ps2
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic w_evt;
  logic w_evt_dat;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_line_filter (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .i_ps2_clk (ps2.PS2_CLK),
    .i_ps2_dat (ps2.PS2_DAT),
    .o_evt     (w_evt),
    .o_evt_dat (w_evt_dat)
  );

  ps2_state_e            r_state,   w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]            r_shift,   w_shift_nxt;
  logic                  r_parity,  w_parity_nxt;
  logic [TO_W-1:0]       r_to_cnt,  w_to_cnt_nxt;
  logic                  r_e0,      w_e0_nxt;
  logic [E1_CNT_W-1:0]   r_e1_cnt,  w_e1_nxt;
  logic                  r_strobe,  w_strobe_nxt;
  logic [7:0]            r_data,    w_data_nxt;
  logic                  r_ext,     w_ext_nxt;
  logic                  r_err,     w_err_nxt;
  logic                  w_frame_end;
  logic                  w_frame_ok;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_e0      <= 1'b0;
      r_e1_cnt  <= '0;
      r_strobe  <= 1'b0;
      r_data    <= 8'h00;
      r_ext     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_e0      <= w_e0_nxt;
      r_e1_cnt  <= w_e1_nxt;
      r_strobe  <= w_strobe_nxt;
      r_data    <= w_data_nxt;
      r_ext     <= w_ext_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_to_cnt_nxt  = r_to_cnt;
    w_e0_nxt      = r_e0;
    w_e1_nxt      = r_e1_cnt;
    w_strobe_nxt  = 1'b0;
    w_data_nxt    = r_data;
    w_ext_nxt     = r_ext;
    w_err_nxt     = 1'b0;
    w_frame_end   = 1'b0;
    w_frame_ok    = 1'b0;

    if ((r_state == IDLE) || w_evt) begin
      w_to_cnt_nxt = '0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + TO_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (w_evt && !w_evt_dat) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_evt) begin
          w_shift_nxt   = {w_evt_dat, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (r_bit_cnt == BIT_CNT_W'(7)) begin
            w_state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        if (w_evt) begin
          w_parity_nxt = w_evt_dat;
          w_state_nxt  = STOP;
        end
      end
      STOP: begin
        if (w_evt) begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
          w_frame_ok  = w_evt_dat && (^{r_shift, r_parity});
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Stalled line mid-frame; a coincident sample event takes precedence
    if ((r_state != IDLE) && !w_evt && (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
      w_state_nxt = IDLE;
      w_frame_end = 1'b1;
      w_frame_ok  = 1'b0;
    end

    if (w_frame_end) begin
      if (!w_frame_ok) begin
        w_err_nxt = 1'b1;
        w_e0_nxt  = 1'b0;
        w_e1_nxt  = '0;
      end else if (r_e1_cnt != '0) begin
        w_e1_nxt = r_e1_cnt - E1_CNT_W'(1);
      end else if (r_shift == PS2_E1) begin
        w_e1_nxt = E1_SKIP;
      end else if (r_shift == PS2_E0) begin
        w_e0_nxt = 1'b1;
      end else begin
        w_strobe_nxt = 1'b1;
        w_data_nxt   = r_shift;
        w_ext_nxt    = r_e0;
        // E0 must survive F0 so the following break code is still extended
        if (r_shift != PS2_F0) begin
          w_e0_nxt = 1'b0;
        end
      end
    end
  end

  assign ps2.ps2_data_clk = r_strobe;
  assign ps2.ps2_data     = r_data;
  assign ps2.ps2_ext      = r_ext;
  assign ps2.frame_err    = r_err;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: drives PS/2 frames, predicts strobes and
// frame errors, and compares them as the receiver produces them.
module tb_ps2_rx_ctrl;

  localparam int unsigned FILT_LEN = 8;
  localparam int unsigned TIMEOUT  = 400;
  localparam int unsigned HALF     = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ps2_rx_ctrl_if bus();

  ps2_rx_ctrl #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .ps2      (bus)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic       ext;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       m_e0   = 1'b0;
  int         m_e1   = 0;
  logic [7:0] m_last = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode of one received frame
  task automatic model(input logic [7:0] b, input bit ok);
    exp_t e;
    if (!ok) begin
      e = '{1'b1, m_last, 1'b0};
      sb.push_back(e);
      m_e0 = 1'b0;
      m_e1 = 0;
    end else if (m_e1 != 0) begin
      m_e1--;
    end else if (b == 8'hE1) begin
      m_e1 = 7;
    end else if (b == 8'hE0) begin
      m_e0 = 1'b1;
    end else begin
      e = '{1'b0, b, m_e0};
      sb.push_back(e);
      m_last = b;
      if (b != 8'hF0) m_e0 = 1'b0;
    end
  endtask

  task automatic send_bit(input logic v);
    bus.PS2_DAT = v;
    repeat (10) @(posedge clk);
    bus.PS2_CLK = 1'b0;
    repeat (HALF) @(posedge clk);
    bus.PS2_CLK = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
  endtask

  task automatic tx(input logic [7:0] b);
    model(b, 1'b1);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.ps2_data_clk || bus.frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {30'd0, bus.ps2_data_clk, bus.frame_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("kind_err", bus.frame_err, mon_e.is_err);
        check("kind_strobe", bus.ps2_data_clk, !mon_e.is_err);
        check("data", bus.ps2_data, mon_e.data);
        if (!mon_e.is_err) check("ext", bus.ps2_ext, mon_e.ext);
      end
    end
  end

  logic [7:0] pause_seq [8];

  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_strobe", bus.ps2_data_clk, 0);
    check("rst_data", bus.ps2_data, 0);
    check("rst_ext", bus.ps2_ext, 0);
    check("rst_err", bus.frame_err, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    tx(8'h1C);
    tx(8'hE0); tx(8'hF0); tx(8'h75); tx(8'h1C);

    model(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    model(8'h33, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 11);

    // Start plus four data bits, then a stalled line
    model(8'h55, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 5);
    repeat (TIMEOUT - 60) @(posedge clk);
    check("timeout_not_early", sb.size(), 1);
    repeat (120) @(posedge clk);
    check("timeout_fired", sb.size(), 0);
    tx(8'h29);

    tx(8'hE0);
    model(8'h12, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 11);
    tx(8'h1C);

    foreach (pause_seq[i]) tx(pause_seq[i]);
    tx(8'h5A);

    bus.PS2_DAT = 1'b0;
    bus.PS2_CLK = 1'b0;
    repeat (3) @(posedge clk);
    bus.PS2_CLK = 1'b1;
    repeat (40) @(posedge clk);
    tx(8'h1C);

    tx(8'h2B);
    tx(8'hE0);
    send_frame(8'h44, 1'b0, 1'b1, 6);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_strobe", bus.ps2_data_clk, 0);
    check("midrst_data", bus.ps2_data, 0);
    check("midrst_ext", bus.ps2_ext, 0);
    check("midrst_err", bus.frame_err, 0);
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    m_e0   = 1'b0;
    m_e1   = 0;
    m_last = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    tx(8'h1C);

    repeat (50) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter FILT_LEN, default 8, consecutive equal samples needed to accept a PS2_CLK level change.
REQ-002 Parameter TIMEOUT, default 50000, CLOCK_50 cycles allowed between filtered falling edges inside a frame.
REQ-003 CLOCK_50  in  1  system clock; the block has one clock.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 PS2_CLK  in  1  raw PS/2 clock line, asynchronous.
REQ-006 PS2_DAT  in  1  raw PS/2 data line, asynchronous.
REQ-007 ps2_data_clk  out  1  one-cycle strobe: ps2_data valid, feeds the keyboard matrix block.
REQ-008 ps2_data  out  8  last accepted scan code byte.
REQ-009 ps2_ext  out  1  ps2_data was preceded by an E0 prefix.
REQ-010 frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-011 PS2_CLK and PS2_DAT SHALL pass through a 2-flop synchronizer; PS2_CLK SHALL then pass through a FILT_LEN glitch filter.
REQ-012 The filtered PS2_CLK 1->0 transition SHALL generate a single-cycle sample event; PS2_DAT (synchronized) is sampled on that event.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: sample 0 -> DATA with bit counter 0; sample 1 -> stay IDLE, no error.
REQ-015 DATA: shift bits LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: store the bit; -> STOP.
REQ-017 STOP: -> IDLE always; frame valid only if the stop bit is 1 and data+parity have odd parity.
REQ-018 Timeout counter SHALL reset on every sample event and in IDLE; reaching TIMEOUT outside IDLE -> IDLE, frame discarded, frame_err pulse.
REQ-019 Invalid frame: frame_err high for one cycle, no strobe, E0 flag and E1 counter cleared.
REQ-020 Valid byte E0: set E0 flag, no strobe.
REQ-021 Valid byte E1: load E1 suppress counter with 7, no strobe; each following valid byte decrements it, no strobe, until 0.
REQ-022 Valid byte F0: strobe with ps2_data=F0, ps2_ext=E0 flag; E0 flag kept (extended break sequence E0 F0 xx).
REQ-023 Any other valid byte: strobe, ps2_data=byte, ps2_ext=E0 flag; E0 flag then cleared.
REQ-024 Strobe latency: ps2_data_clk high exactly one CLOCK_50 cycle, in the cycle after the sample event of the stop bit; ps2_data and ps2_ext registered and stable until the next strobe.
REQ-025 Timeout and sample event in the same cycle: sample event wins, counter restarts.

Reset
REQ-026 RESET_N low SHALL asynchronously force: FSM IDLE, bit counter 0, shift register 0, E0 flag 0, E1 counter 0, timeout counter 0, filter output 1, synchronizers 1.
REQ-027 Reset outputs: ps2_data_clk=0, ps2_data=8'h00, ps2_ext=0, frame_err=0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no strobe and no error pulse after release.

Structure
REQ-029 Shared package ps2_pkg: FSM state enum, constants PS2_E0=8'hE0, PS2_E1=8'hE1, PS2_F0=8'hF0.
REQ-030 One sub-module, ps2_line_filter: synchronizers, glitch filter, falling-edge event, parameterized by FILT_LEN.
REQ-031 Timeout counter width SHALL be clog2(TIMEOUT+1); bit counter 3 bits; E1 counter 3 bits.

Verification
REQ-032 Frame 0x1C (odd parity bit 0, stop 1) -> one strobe, ps2_data=1C, ps2_ext=0, frame_err stays 0.
REQ-033 Frames E0,F0,75 -> strobes F0 (ext=1) then 75 (ext=1); no strobe for E0; ps2_ext=0 on a following 1C.
REQ-034 Frame 0x1C with parity bit 1 -> frame_err pulse, no strobe, ps2_data unchanged.
REQ-035 Stop after 4 data bits, idle TIMEOUT cycles -> frame_err at cycle TIMEOUT, FSM IDLE; next frame 0x29 strobes correctly.
REQ-036 Pause sequence E1 14 77 E1 F0 14 F0 77 -> zero strobes; next 0x5A strobes.
REQ-037 3-cycle PS2_CLK low glitch with FILT_LEN=8 -> no sample event; RESET_N low at bit 5 -> no strobe, outputs reset values.
